// File: rtl/iterative_alu.sv
// iterative_alu: execute-stage ALU with valid/ready handshakes on both sides.
// Base integer ops complete one cycle after accept. M-extension multiply and
// divide run iteratively, one shift-add or restoring-subtract step per cycle,
// for XLEN cycles.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 synchronous kill of any in-flight op or held result
//   in_valid / in_ready   operand handshake (in_ready only while idle)
//   src1, src2, alu_ctrl  operands and op select
//   out_valid / out_ready result handshake
//   alu_result            registered result, stable while out_valid is high
//
// state | meaning
// IDLE  | waiting for an op, in_ready=1
// BUSY  | iterating a mul/div, counter counts XLEN down to 1
// DONE  | result presented, waiting for out_ready
module iterative_alu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      alu_ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  // mul: product register; div: {remainder, quotient/dividend}
  logic [2*XLEN-1:0] acc_q, acc_d;
  // mul: multiplicand magnitude; div: divisor magnitude
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        mop_q, mop_d;
  logic              neg_q, neg_d;

  // ---------------- base ops ----------------
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] sum, base_res;

  assign shamt = src2[SHW-1:0];
  assign sum   = src1 + src2;

  always_comb begin
    base_res = '0;
    case (alu_ctrl)
      5'b00000: base_res = sum;
      5'b00001: base_res = src2;
      5'b00010: base_res = src1 - src2;
      5'b00011: base_res = sum & {{(XLEN-1){1'b1}}, 1'b0};
      5'b00100: base_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
      5'b00101: base_res = src1 ^ src2;
      5'b00110: base_res = src1 | src2;
      5'b00111: base_res = src1 & src2;
      5'b01000: base_res = src1 << shamt;
      5'b01001: base_res = $signed(src1) >>> shamt;
      5'b01010: base_res = src1 >> shamt;
      5'b01100: base_res = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      default:  base_res = '0;
    endcase
  end

  // ---------------- M-op decode at accept ----------------
  logic            is_mop, is_div, s1_signed, s2_signed, s1_neg, s2_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] mag1, mag2, special_res;

  assign is_mop    = (alu_ctrl[4:3] == 2'b10);
  assign is_div    = is_mop & alu_ctrl[2];
  // signed src1: mulh, mulhsu, div, rem; signed src2: mulh, div, rem
  assign s1_signed = (alu_ctrl[2:0] == 3'b001) | (alu_ctrl[2:0] == 3'b010) |
                     (alu_ctrl[2:0] == 3'b100) | (alu_ctrl[2:0] == 3'b110);
  assign s2_signed = (alu_ctrl[2:0] == 3'b001) |
                     (alu_ctrl[2:0] == 3'b100) | (alu_ctrl[2:0] == 3'b110);
  assign s1_neg    = s1_signed & src1[XLEN-1];
  assign s2_neg    = s2_signed & src2[XLEN-1];
  assign mag1      = s1_neg ? -src1 : src1;
  assign mag2      = s2_neg ? -src2 : src2;

  assign div_zero  = is_div & (src2 == '0);
  assign div_ovf   = is_div & ~alu_ctrl[0] &
                     (src1 == {1'b1, {(XLEN-1){1'b0}}}) & (src2 == '1);

  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = alu_ctrl[1] ? src1 : '1;
    else if (div_ovf) special_res = alu_ctrl[1] ? '0 : src1;
  end

  // ---------------- one iteration step ----------------
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic              ge;
  logic [2*XLEN-1:0] mul_next, div_next, step, full;
  logic [XLEN-1:0]   quo, rem, fin_res;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign ge       = (rem_sh >= {1'b0, opb_q});
  assign diff     = rem_sh - {1'b0, opb_q};
  assign div_next = {(ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                     acc_q[XLEN-2:0], ge};

  assign step = mop_q[2] ? div_next : mul_next;

  // sign fix-up: products negate as a whole, quotient/remainder per field
  assign full = neg_q ? -step : step;
  assign quo  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
  assign rem  = neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];

  always_comb begin
    fin_res = '0;
    case (mop_q)
      3'b000:                 fin_res = full[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = full[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = quo;
      default:                fin_res = rem;
    endcase
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    mop_d    = mop_q;
    neg_d    = neg_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (is_mop && !div_zero && !div_ovf) begin
              mop_d   = alu_ctrl[2:0];
              cnt_d   = CW'(XLEN);
              state_d = S_BUSY;
              if (is_div) begin
                acc_d = {{XLEN{1'b0}}, mag1};
                opb_d = mag2;
                neg_d = alu_ctrl[1] ? s1_neg : (s1_neg ^ s2_neg);
              end else begin
                acc_d = {{XLEN{1'b0}}, mag2};
                opb_d = mag1;
                neg_d = s1_neg ^ s2_neg;
              end
            end else begin
              result_d = is_mop ? special_res : base_res;
              state_d  = S_DONE;
            end
          end
        end
        S_BUSY: begin
          acc_d = step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            result_d = fin_res;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      mop_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      mop_q    <= mop_d;
      neg_q    <= neg_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign alu_result = result_q;

endmodule

// File: tb/tb_iterative_alu.sv
module tb_iterative_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;

  logic        fl32, v32, ir32, ov32, rdy32;
  logic [31:0] a32, b32, r32;
  logic [4:0]  c32;
  logic        fl64, v64, ir64, ov64, rdy64;
  logic [63:0] a64, b64, r64;
  logic [4:0]  c64;

  always #5 clk = ~clk;

  iterative_alu #(.XLEN(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(fl32), .in_valid(v32), .in_ready(ir32),
    .src1(a32), .src2(b32), .alu_ctrl(c32), .out_valid(ov32),
    .out_ready(rdy32), .alu_result(r32));

  iterative_alu #(.XLEN(64)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(fl64), .in_valid(v64), .in_ready(ir64),
    .src1(a64), .src2(b64), .alu_ctrl(c64), .out_valid(ov64),
    .out_ready(rdy64), .alu_result(r64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for out_valid (bounded), check latency and result,
  // then take the result with a one-cycle out_ready pulse.
  // Latency counts clock edges from the accepting edge (inclusive) until
  // out_valid is seen: 1 for base ops, XLEN+1 for iterative ops.
  task automatic run_op(input bit w64, input logic [4:0] ctrl,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat, input string tag);
    int lat;
    if (w64) begin v64 = 1'b1; c64 = ctrl; a64 = a; b64 = b; end
    else     begin v32 = 1'b1; c32 = ctrl; a32 = a[31:0]; b32 = b[31:0]; end
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0;
    lat = 1;
    while (!(w64 ? ov64 : ov32) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, w64 ? r64 : {32'b0, r32}, exp);
    if (w64) rdy64 = 1'b1; else rdy32 = 1'b1;
    @(posedge clk); #1;
    rdy32 = 1'b0; rdy64 = 1'b0;
    chk({tag, " in_ready after take"}, {63'b0, (w64 ? ir64 : ir32)}, 64'd1);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    fl32 = 0; v32 = 0; rdy32 = 0; a32 = 0; b32 = 0; c32 = 0;
    fl64 = 0; v64 = 0; rdy64 = 0; a64 = 0; b64 = 0; c64 = 0;
    #22;
    chk("reset in_ready", {63'b0, ir32}, 64'd1);
    chk("reset out_valid", {63'b0, ov32}, 64'd0);
    chk("reset result", {32'b0, r32}, 64'd0);
    chk("reset64 out_valid", {63'b0, ov64}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // base ops
    run_op(0, 5'b00000, 64'hFFFFFFFF, 64'h1, 64'h0, 1, "add wrap");
    run_op(0, 5'b01001, 64'h80000000, 64'h24, 64'hF8000000, 1, "sra");
    run_op(0, 5'b01010, 64'h80000000, 64'h24, 64'h08000000, 1, "srl");
    run_op(0, 5'b00010, 64'h5, 64'h7, 64'hFFFFFFFE, 1, "sub");
    run_op(0, 5'b00011, 64'h1001, 64'h2, 64'h1002, 1, "jalr target");
    run_op(0, 5'b01100, 64'hFFFFFFFF, 64'h1, 64'h1, 1, "slt");
    run_op(0, 5'b00100, 64'hFFFFFFFF, 64'h1, 64'h0, 1, "sltu");
    run_op(0, 5'b01011, 64'h1234, 64'h5678, 64'h0, 1, "illegal");

    // multiply
    run_op(0, 5'b10000, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000001, 33, "mul");
    run_op(0, 5'b10011, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33, "mulhu");
    run_op(0, 5'b10001, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000000, 33, "mulh");
    run_op(0, 5'b10010, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 33, "mulhsu");
    run_op(0, 5'b10000, 64'h12345, 64'h1000, 64'h12345000, 33, "mul small");

    // divide
    run_op(0, 5'b10100, 64'hFFFFFFF9, 64'h2, 64'hFFFFFFFD, 33, "div -7/2");
    run_op(0, 5'b10110, 64'hFFFFFFF9, 64'h2, 64'hFFFFFFFF, 33, "rem -7/2");
    run_op(0, 5'b10101, 64'd100, 64'd7, 64'd14, 33, "divu 100/7");
    run_op(0, 5'b10111, 64'd100, 64'd7, 64'd2, 33, "remu 100/7");
    run_op(0, 5'b10101, 64'h7, 64'h0, 64'hFFFFFFFF, 1, "divu by zero");
    run_op(0, 5'b10111, 64'h7, 64'h0, 64'h7, 1, "remu by zero");
    run_op(0, 5'b10100, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1, "div overflow");
    run_op(0, 5'b10110, 64'h80000000, 64'hFFFFFFFF, 64'h0, 1, "rem overflow");

    // backpressure: 1+2 held for 5 cycles
    v32 = 1'b1; c32 = 5'b00000; a32 = 32'd1; b32 = 32'd2;
    @(posedge clk); #1;
    v32 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", {63'b0, ov32}, 64'd1);
      chk("bp result", {32'b0, r32}, 64'd3);
      chk("bp in_ready", {63'b0, ir32}, 64'd0);
      @(posedge clk); #1;
    end
    rdy32 = 1'b1;
    @(posedge clk); #1;
    rdy32 = 1'b0;
    chk("bp release in_ready", {63'b0, ir32}, 64'd1);
    chk("bp release out_valid", {63'b0, ov32}, 64'd0);

    // flush at BUSY cycle 10 of a div
    v32 = 1'b1; c32 = 5'b10100; a32 = 32'd100; b32 = 32'd7;
    @(posedge clk); #1;
    v32 = 1'b0;
    for (int i = 1; i < 10; i++) begin @(posedge clk); #1; end
    chk("flush pre busy", {63'b0, ir32}, 64'd0);
    fl32 = 1'b1;
    @(posedge clk); #1;
    fl32 = 1'b0;
    chk("flush in_ready", {63'b0, ir32}, 64'd1);
    chk("flush result kept", {32'b0, r32}, 64'd3);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ov32) seen++;
      @(posedge clk); #1;
    end
    chk("flush no out_valid", 64'(seen), 64'd0);
    run_op(0, 5'b00000, 64'd3, 64'd4, 64'd7, 1, "add after flush");

    // flush wins over simultaneous accept
    v32 = 1'b1; fl32 = 1'b1; c32 = 5'b00000; a32 = 32'd9; b32 = 32'd9;
    @(posedge clk); #1;
    v32 = 1'b0; fl32 = 1'b0;
    chk("flush vs accept out_valid", {63'b0, ov32}, 64'd0);
    chk("flush vs accept in_ready", {63'b0, ir32}, 64'd1);

    // reset mid-BUSY
    v32 = 1'b1; c32 = 5'b10000; a32 = 32'd6; b32 = 32'd7;
    @(posedge clk); #1;
    v32 = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("rst mid-busy out_valid", {63'b0, ov32}, 64'd0);
    chk("rst mid-busy result", {32'b0, r32}, 64'd0);
    chk("rst mid-busy in_ready", {63'b0, ir32}, 64'd1);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 5'b10000, 64'd6, 64'd7, 64'd42, 33, "mul after reset");

    // XLEN = 64
    run_op(1, 5'b01100, 64'h8000000000000000, 64'h1, 64'h1, 1, "x64 slt");
    run_op(1, 5'b01000, 64'h1, 64'd63, 64'h8000000000000000, 1, "x64 sll");
    run_op(1, 5'b10011, 64'h8000000000000000, 64'h4, 64'h2, 65, "x64 mulhu");
    run_op(1, 5'b10000, 64'h8000000000000000, 64'h4, 64'h0, 65, "x64 mul");
    run_op(1, 5'b10100, 64'hFFFFFFFFFFFFFF9C, 64'd7, 64'hFFFFFFFFFFFFFFF2, 65, "x64 div -100/7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Parametrised, handshaked successor to the single-cycle execute ALU.
- Executes all base integer ops (add/sub/logic/shift/compare/lui/jalr-target) with 1-cycle latency.
- Adds RV M-extension multiply/divide, computed iteratively over XLEN cycles.
- Sits in the EXU between decode and writeback; valid/ready on both sides lets the pipeline stall on long ops.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SHW, $clog2(XLEN), shift-amount width taken from src2[SHW-1:0].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous kill of any in-flight op.
- in_valid  in  1  operands/op valid.
- in_ready  out  1  block can accept an op.
- src1  in  XLEN  operand 1.
- src2  in  XLEN  operand 2 / immediate.
- alu_ctrl  in  5  op select.
- out_valid  out  1  alu_result valid.
- out_ready  in  1  consumer accepts result.
- alu_result  out  XLEN  registered result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, alu_result=0, counter=0, all internal product/quotient registers=0.
- Base op codes, alu_ctrl[4]=0:
  - 00000 add; 00001 pass src2; 00010 sub; 00011 (src1+src2)&~1.
  - 00100 sltu; 00101 xor; 00110 or; 00111 and.
  - 01000 sll; 01001 sra (arithmetic, sign-filled); 01010 srl.
  - 01100 slt signed.
  - Compare results are zero-extended 0/1. Shift amount is src2[SHW-1:0].
- M op codes, alu_ctrl[4]=1:
  - 10000 mul (low XLEN); 10001 mulh (s×s); 10010 mulhsu (src1 signed, src2 unsigned); 10011 mulhu.
  - 10100 div; 10101 divu; 10110 rem; 10111 remu.
- Any other code: result 0, base-op timing.
- State machine: IDLE, BUSY, DONE.
  - in_ready=1 only in IDLE. Accept = in_valid & in_ready & ~flush.
  - IDLE, accept of base op or illegal code: result registered that edge, then DONE.
  - IDLE, accept of M op: operands latched as magnitudes plus sign flags, counter=XLEN, then BUSY.
  - BUSY: one shift-add (mul) or one restoring-subtract (div) step per cycle; counter decrements. When counter==1, apply sign fix-up (negate per sign rules), write alu_result, go to DONE. BUSY lasts exactly XLEN cycles.
  - DONE: out_valid=1. alu_result and out_valid hold stable until out_ready=1, then IDLE. No new op is accepted in DONE, so there is no back-to-back overlap.
- Latency (accept at edge N):
  - Base op: out_valid high from N+1.
  - M op: out_valid high from N+XLEN+1.
- Division specials resolve at accept and go straight to DONE (1-cycle latency):
  - Divide by zero: div/divu quotient = all ones; rem/remu = src1.
  - Signed overflow (src1 = most-negative, src2 = -1): div = src1; rem = 0.
- Signed remainder takes the sign of the dividend. Signed quotient is negative iff operand signs differ and the divisor is nonzero.
- flush=1 in any state: next state IDLE, out_valid=0, counter=0; alu_result keeps its old value.
  - flush wins over a simultaneous accept (op dropped).
  - flush wins over a simultaneous out_ready (result discarded).
- rst_n falling mid-BUSY: immediate return to reset values. No partial result is ever presented.
- All arithmetic wraps modulo 2^XLEN. The product register is 2·XLEN wide; mulh* return bits [2·XLEN-1:XLEN].

Test Plan:
- XLEN=32, add 0xFFFFFFFF+1; sra 0x80000000 by src2=0x24 (shamt 4) -> add gives 0x00000000 with out_valid one cycle after accept; sra gives 0xF8000000.
- mul 0xFFFFFFFF×0xFFFFFFFF: mul -> 0x00000001; mulhu -> 0xFFFFFFFE; mulh -> 0x00000000; mulhsu -> 0xFFFFFFFF. out_valid exactly 33 cycles after accept each time.
- div -7/2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF; divu 7/0 -> 0xFFFFFFFF at 1-cycle latency; div 0x80000000/0xFFFFFFFF -> 0x80000000, rem -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and out_valid stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
- flush asserted at BUSY cycle 10 of a div -> IDLE next cycle, out_valid never rises; a following add 3+4 returns 7. rst_n pulsed low mid-BUSY -> out_valid=0 and alu_result=0 immediately.
- XLEN=64: slt 0x8000000000000000 vs 1 -> 1; sll 1 by 63 -> 0x8000000000000000; mulhu 2^63×4 -> 2; latency 65 cycles.
